// File: rtl/lock_controller.sv
// Keypad-to-checker sequencer: turns debounced key/enter/set pulses into checker
// strobes and resets, and tracks lock state, wrong attempts and lockout time.
module lock_controller #(
  parameter int PW_LEN         = 4,
  parameter int MAX_ATTEMPTS   = 3,
  parameter int LOCKOUT_CYCLES = 50000000,
  parameter int CNT_W          = 26
) (
  input  logic       clk,
  input  logic       input_reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       enter_btn,
  input  logic       set_btn,
  input  logic       correct_password,
  input  logic       incorrect_password,
  output logic       input_value,
  output logic       store_value,
  output logic       compare,
  output logic [3:0] bits,
  output logic       chk_input_reset_n,
  output logic       chk_system_reset_n,
  output logic       unlocked,
  output logic       locked_out,
  output logic [1:0] attempts_left,
  output logic [2:0] state_dbg
);

  localparam int DC_W = $clog2(PW_LEN + 1);
  localparam logic [DC_W-1:0]  PW_CNT    = DC_W'(PW_LEN);
  localparam logic [1:0]       ATT_MAX   = 2'(MAX_ATTEMPTS);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_INIT     = 3'd0,
    S_SET      = 3'd1,
    S_LOCKED   = 3'd2,
    S_CHECK    = 3'd3,
    S_UNLOCKED = 3'd4,
    S_LOCKOUT  = 3'd5
  } state_t;

  function automatic logic [1:0] sat_dec(input logic [1:0] v);
    return (v == 2'd0) ? 2'd0 : v - 2'd1;
  endfunction

  state_t            state, state_nx;
  logic              init_p, init_nx;
  logic [DC_W-1:0]   dcnt, dcnt_nx;
  logic              vld_p0, vld_nx;
  logic [3:0]        bits_nx;
  logic              iv_nx, sv_nx, cmp_nx, cir_nx, csr_nx;
  logic              unl_nx, lko_nx;
  logic [1:0]        att_nx, att_dec;
  logic [1:0]        tmr, tmr_nx;
  logic [CNT_W-1:0]  lock_cnt, lock_nx;
  logic              in_flight, digit_ok, entry_done;

  assign state_dbg = state;
  assign in_flight = vld_p0 | input_value | store_value;
  assign digit_ok  = key_valid && !enter_btn && !in_flight && (dcnt < PW_CNT);
  // Enter is held off while a digit is still on its way so compare never overlaps a strobe.
  assign entry_done = enter_btn && (dcnt != '0) && !in_flight;
  assign att_dec   = sat_dec(attempts_left);

  always_ff @(posedge clk or negedge input_reset) begin
    if (!input_reset) begin
      state              <= S_INIT;
      init_p             <= 1'b0;
      dcnt               <= '0;
      vld_p0             <= 1'b0;
      bits               <= 4'd0;
      input_value        <= 1'b0;
      store_value        <= 1'b0;
      compare            <= 1'b0;
      chk_input_reset_n  <= 1'b0;
      chk_system_reset_n <= 1'b0;
      unlocked           <= 1'b0;
      locked_out         <= 1'b0;
      attempts_left      <= ATT_MAX;
      tmr                <= 2'd0;
      lock_cnt           <= '0;
    end else begin
      state              <= state_nx;
      init_p             <= init_nx;
      dcnt               <= dcnt_nx;
      vld_p0             <= vld_nx;
      bits               <= bits_nx;
      input_value        <= iv_nx;
      store_value        <= sv_nx;
      compare            <= cmp_nx;
      chk_input_reset_n  <= cir_nx;
      chk_system_reset_n <= csr_nx;
      unlocked           <= unl_nx;
      locked_out         <= lko_nx;
      attempts_left      <= att_nx;
      tmr                <= tmr_nx;
      lock_cnt           <= lock_nx;
    end
  end

  always_comb begin
    state_nx = state;
    init_nx  = init_p;
    dcnt_nx  = dcnt;
    vld_nx   = 1'b0;
    bits_nx  = bits;
    cmp_nx   = 1'b0;
    cir_nx   = 1'b1;
    csr_nx   = 1'b1;
    att_nx   = attempts_left;
    tmr_nx   = tmr;
    lock_nx  = lock_cnt;
    // Digit stage p0 -> strobe: the strobe kind follows the state the digit was taken in.
    iv_nx    = vld_p0 && (state == S_LOCKED);
    sv_nx    = vld_p0 && (state == S_SET);

    unique case (state)
      S_INIT: begin
        cir_nx = 1'b0;
        csr_nx = 1'b0;
        if (!init_p) begin
          init_nx = 1'b1;
        end else begin
          cir_nx   = 1'b1;
          csr_nx   = 1'b1;
          state_nx = S_SET;
        end
      end
      S_SET, S_LOCKED: begin
        if (entry_done) begin
          dcnt_nx = '0;
          if (state == S_SET) begin
            state_nx = S_LOCKED;
          end else begin
            state_nx = S_CHECK;
            cmp_nx   = 1'b1;
            tmr_nx   = 2'd0;
          end
        end else if (digit_ok) begin
          bits_nx = key_code;
          vld_nx  = 1'b1;
          dcnt_nx = dcnt + DC_W'(1);
        end
      end
      S_CHECK: begin
        if (tmr == 2'd2) begin
          cir_nx = 1'b0;
          if (correct_password && !incorrect_password) begin
            state_nx = S_UNLOCKED;
            att_nx   = ATT_MAX;
          end else begin
            att_nx = att_dec;
            if (att_dec == 2'd0) begin
              state_nx = S_LOCKOUT;
              lock_nx  = '0;
            end else begin
              state_nx = S_LOCKED;
            end
          end
        end else begin
          tmr_nx = tmr + 2'd1;
        end
      end
      S_UNLOCKED: begin
        if (set_btn) begin
          csr_nx   = 1'b0;
          state_nx = S_SET;
        end else if (enter_btn) begin
          cir_nx   = 1'b0;
          state_nx = S_LOCKED;
        end
      end
      S_LOCKOUT: begin
        if (lock_cnt == LOCK_LAST) begin
          lock_nx  = '0;
          att_nx   = ATT_MAX;
          state_nx = S_LOCKED;
        end else begin
          lock_nx = lock_cnt + CNT_W'(1);
        end
      end
      default: state_nx = S_INIT;
    endcase

    unl_nx = (state_nx == S_UNLOCKED);
    lko_nx = (state_nx == S_LOCKOUT);
  end

endmodule
